// File: rtl/nivel_sens_filtro.sv
// Tank-level sensor conditioner: 2-flop sync, per-bit debounce, thermometer-code check and fault FSM.
// Optional build macro LVL_ACTIVE_LOW_EN selects active-low raw sensor pins.
module nivel_sens_filtro #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FAULT_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw_i,
  output logic [2:0] sens_o,
  output logic       change_o,
  output logic       fault_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(FAULT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FAULT_MAX = FW'(FAULT_CYCLES);
  localparam logic [FW-1:0] FCNT_ONE  = FW'(1);

`ifdef LVL_ACTIVE_LOW_EN
  // Idle (dry) active-low pins read high, so the flops start there.
  localparam logic [2:0] SYNC_RST = 3'b111;
`else
  localparam logic [2:0] SYNC_RST = 3'b000;
`endif

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  logic [2:0]    sync1_reg;
  logic [2:0]    sync2_reg;
  logic [2:0]    sens_sync;
  logic [2:0]    stable_reg;
  logic [2:0]    stable_next;
  logic          legal;
  state_t        state_reg;
  state_t        state_next;
  logic [FW-1:0] fcnt_reg;
  logic [FW-1:0] fcnt_next;
  logic [FW-1:0] fcnt_inc;
  logic          fault_reg;
  logic          fault_next;
  logic [2:0]    last_valid_reg;
  logic [2:0]    last_valid_next;
  logic          change_reg;
  logic          change_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= SYNC_RST;
      sync2_reg <= SYNC_RST;
    end else begin
      sync1_reg <= raw_i;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef LVL_ACTIVE_LOW_EN
  assign sens_sync = ~sync2_reg;
`else
  assign sens_sync = sync2_reg;
`endif

  // Each bit owns its counter, so simultaneous pin edges may settle on different cycles.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic [DW-1:0] cnt_reg;
      logic [DW-1:0] cnt_next;
      logic          differ;
      logic          expire;

      assign differ = (sens_sync[gi] != stable_reg[gi]);
      assign expire = differ && (cnt_reg == DEB_LAST);
      assign cnt_next = (!differ || expire) ? '0 : cnt_reg + DW'(1);
      assign stable_next[gi] = expire ? sens_sync[gi] : stable_reg[gi];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_reg <= 3'b000;
    end else begin
      stable_reg <= stable_next;
    end
  end

  always_comb begin
    legal = 1'b0;
    case (stable_reg)
      3'b000, 3'b001, 3'b011, 3'b111: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
  end

  assign fcnt_inc = (fcnt_reg == FAULT_MAX) ? fcnt_reg : fcnt_reg + FCNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_OK;
      fcnt_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    fault_next = fault_reg;
    case (state_reg)
      ST_OK: begin
        if (!legal) begin
          state_next = ST_SUSPECT;
          fcnt_next  = FCNT_ONE;
        end
      end
      ST_SUSPECT: begin
        if (legal) begin
          state_next = ST_OK;
          fcnt_next  = '0;
        end else if (fcnt_inc == FAULT_MAX) begin
          state_next = ST_FAULT;
          fcnt_next  = '0;
          fault_next = 1'b1;
        end else begin
          fcnt_next = fcnt_inc;
        end
      end
      ST_FAULT: begin
        if (legal) begin
          state_next = ST_RECOVER;
          fcnt_next  = FCNT_ONE;
        end
      end
      ST_RECOVER: begin
        if (!legal) begin
          state_next = ST_FAULT;
          fcnt_next  = '0;
        end else if (fcnt_inc == FAULT_MAX) begin
          state_next = ST_OK;
          fcnt_next  = '0;
          fault_next = 1'b0;
        end else begin
          fcnt_next = fcnt_inc;
        end
      end
      default: begin
        state_next = ST_OK;
        fcnt_next  = '0;
        fault_next = 1'b0;
      end
    endcase
  end

  // Only legal codes are forwarded; the pump controller never sees an illegal vector.
  assign last_valid_next = legal ? stable_reg : last_valid_reg;
  assign change_next     = (last_valid_next != last_valid_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_valid_reg <= 3'b000;
      change_reg     <= 1'b0;
    end else begin
      last_valid_reg <= last_valid_next;
      change_reg     <= change_next;
    end
  end

  assign sens_o   = last_valid_reg;
  assign change_o = change_reg;
  assign fault_o  = fault_reg;

endmodule
